// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: hit/miss controller and datapath glue for a direct-mapped,
// write-back, write-allocate L1 data cache (32 lines x 256 bit, 8 words/line).
// The tag and data arrays live outside this block as single-port SRAMs with a
// combinational read of row sram_index; writes commit on the clock edge.
// Optional feature: define L1_CACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
module l1_cache_ctrl #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 5,
  parameter int TAG_W    = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr,
  input  logic         cs,
  input  logic         we,
  input  logic [31:0]  data_i,
  output logic [31:0]  data_o,
  output logic         stall,
  output logic [4:0]   sram_index,
  input  logic [23:0]  tag_rd,
  input  logic [255:0] line_rd,
  output logic         sram_cs,
  output logic         sram_we,
  output logic [23:0]  tag_wr,
  output logic [255:0] line_wr,
  output logic         mem_cs,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic               w_valid;
  logic               w_dirty;
  logic               w_tag_match;
  logic               w_hit;
  logic [31:0]        w_rd_word;
  logic [255:0]       w_merge_line;
  logic               w_unused;

  // Address split; the valid bit comes from the internal vector because the
  // SRAM's stored valid bit is stale after a reset.
  assign w_index     = addr[OFFSET_W +: INDEX_W];
  assign w_tag       = addr[OFFSET_W+INDEX_W +: TAG_W];
  assign w_word      = addr[4:2];
  assign w_valid     = r_valid[w_index];
  assign w_dirty     = tag_rd[TAG_W];
  assign w_tag_match = (tag_rd[TAG_W-1:0] == w_tag);
  assign w_hit       = cs & w_valid & w_tag_match;
  assign sram_index  = w_index;
  assign w_unused    = ^{tag_rd[TAG_W+1], addr[1:0]};

  // 8-way read word select from the current SRAM line
  always_comb begin
    w_rd_word = 32'h0000_0000;
    case (w_word)
      3'd0:    w_rd_word = line_rd[31:0];
      3'd1:    w_rd_word = line_rd[63:32];
      3'd2:    w_rd_word = line_rd[95:64];
      3'd3:    w_rd_word = line_rd[127:96];
      3'd4:    w_rd_word = line_rd[159:128];
      3'd5:    w_rd_word = line_rd[191:160];
      3'd6:    w_rd_word = line_rd[223:192];
      3'd7:    w_rd_word = line_rd[255:224];
      default: w_rd_word = 32'h0000_0000;
    endcase
  end

  // 8-way write merge: replace the addressed word with the store data
  always_comb begin
    w_merge_line = line_rd;
    for (int k = 0; k < WORDS; k++) begin
      if (w_word == 3'(k)) begin
        w_merge_line[32*k +: 32] = data_i;
      end else begin
        w_merge_line[32*k +: 32] = line_rd[32*k +: 32];
      end
    end
  end

  // Output decode: CPU handshake, SRAM strobes and memory request per state
  always_comb begin
    data_o     = 32'h0000_0000;
    stall      = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    tag_wr     = 24'h00_0000;
    line_wr    = 256'h0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0000_0000;
    mem_data_o = 256'h0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cs) begin
            sram_cs = 1'b1;
            if (w_hit) begin
              if (we) begin
                sram_we = 1'b1;
                line_wr = w_merge_line;
                tag_wr  = {1'b1, 1'b1, w_tag};
              end else begin
                data_o = w_rd_word;
              end
            end else begin
              stall = 1'b1;
            end
          end else begin
            sram_cs = 1'b0;
          end
        end
        S_WRITEBACK: begin
          stall      = 1'b1;
          sram_cs    = 1'b1;
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = {tag_rd[TAG_W-1:0], w_index, {OFFSET_W{1'b0}}};
          mem_data_o = line_rd;
        end
        S_ALLOCATE: begin
          stall    = 1'b1;
          mem_cs   = 1'b1;
          mem_we   = 1'b0;
          mem_addr = {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
          if (mem_ack) begin
            sram_cs = 1'b1;
            sram_we = 1'b1;
            line_wr = mem_data_i;
            tag_wr  = {1'b1, 1'b0, w_tag};
          end else begin
            sram_we = 1'b0;
          end
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  // Miss FSM and per-line valid tracking; reset aborts any memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cs && !w_hit) begin
            r_state <= (w_valid && w_dirty) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            r_state <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (mem_ack) begin
            r_state          <= S_IDLE;
            r_valid[w_index] <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef L1_CACHE_STATS_EN
  logic r_refill;

  // Access statistics: the hit seen right after a refill belongs to the miss
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'h0000_0000;
      miss_cnt <= 32'h0000_0000;
      r_refill <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cs && w_hit && !r_refill) begin
            hit_cnt <= hit_cnt + 32'h0000_0001;
          end
          if (cs && !w_hit) begin
            miss_cnt <= miss_cnt + 32'h0000_0001;
          end
          r_refill <= 1'b0;
        end
        S_ALLOCATE: begin
          if (mem_ack) begin
            r_refill <= 1'b1;
          end
        end
        default: begin
          r_refill <= r_refill;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl. Holds tag/data SRAM and main-memory
// models, a word-level golden memory and an abstract per-index cache model.
`timescale 1ns/1ps
module tb_l1_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic         cs;
  logic         we;
  logic [31:0]  data_i;
  logic [31:0]  data_o;
  logic         stall;
  logic [4:0]   sram_index;
  logic [23:0]  tag_rd;
  logic [255:0] line_rd;
  logic         sram_cs;
  logic         sram_we;
  logic [23:0]  tag_wr;
  logic [255:0] line_wr;
  logic         mem_cs;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = 256'h0;
  logic         mem_ack = 1'b0;
`ifdef L1_CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  int           exp_hits = 0;
  int           exp_misses = 0;
`endif

  l1_cache_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .cs(cs), .we(we), .data_i(data_i),
    .data_o(data_o), .stall(stall), .sram_index(sram_index), .tag_rd(tag_rd),
    .line_rd(line_rd), .sram_cs(sram_cs), .sram_we(sram_we), .tag_wr(tag_wr),
    .line_wr(line_wr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack(mem_ack)
`ifdef L1_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- environment: SRAMs ----------------
  logic [23:0]  tag_mem  [32];
  logic [255:0] data_mem [32];
  assign tag_rd  = tag_mem[sram_index];
  assign line_rd = data_mem[sram_index];
  always @(posedge clk) begin
    if (sram_cs && sram_we) begin
      tag_mem[sram_index]  <= tag_wr;
      data_mem[sram_index] <= line_wr;
    end
  end

  // ---------------- main memory and golden word view ----------------
  logic [255:0] mm  [logic [26:0]];
  logic [31:0]  ovr [logic [29:0]];

  function automatic logic [31:0] pat(input logic [31:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ {wa[31:16], 16'h0000};
  endfunction

  function automatic logic [255:0] mm_line(input logic [26:0] la);
    logic [255:0] l;
    if (mm.exists(la)) return mm[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = pat({la, 3'(k), 2'b00});
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [255:0] l;
    if (ovr.exists(a[31:2])) return ovr[a[31:2]];
    l = mm_line(a[31:5]);
    return l[{a[4:2], 5'b00000} +: 32];
  endfunction

  function automatic logic [255:0] gold_line(input logic [26:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = gold_word({la, 3'(k), 2'b00});
    return l;
  endfunction

  // abstract cache state: what each index holds after completed accesses
  bit          cm_valid [32];
  logic [21:0] cm_tag   [32];
  bit          cm_dirty [32];

  // memory responder: ack on the ack_lat-th cycle of a request
  int ack_lat  = 2;
  int resp_cnt = 0;
  bit spur_ack = 1'b0;
  always begin
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (spur_ack) begin
      mem_ack = 1'b1;
    end else if (mem_cs && !rst) begin
      resp_cnt++;
      if (resp_cnt >= ack_lat) begin
        mem_ack  = 1'b1;
        resp_cnt = 0;
        if (mem_we) mm[mem_addr[31:5]] = mem_data_o;
        else        mem_data_i = mm_line(mem_addr[31:5]);
      end else begin
        mem_data_i = {8{32'hA5A5_5A5A}};
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic [255:0] exp_l;
    if (!rst) begin
      if (stall) chk("data_o_during_stall", 256'(data_o), 256'h0);
      if (!cs) begin
        chk("idle_stall", 256'(stall), 256'h0);
        chk("idle_mem_cs", 256'(mem_cs), 256'h0);
        chk("idle_sram_we", 256'(sram_we), 256'h0);
        chk("idle_data_o", 256'(data_o), 256'h0);
      end else begin
        chk("sram_index", 256'(sram_index), 256'(addr[9:5]));
        if (!stall && !we) chk("load_data", 256'(data_o), 256'(gold_word(addr)));
        if (!stall && we) begin
          exp_l = gold_line(addr[31:5]);
          exp_l[{addr[4:2], 5'b00000} +: 32] = data_i;
          chk("store_sram_we", 256'(sram_we), 256'h1);
          chk("store_line_wr", line_wr, exp_l);
          chk("store_tag_wr", 256'(tag_wr), 256'({2'b11, addr[31:10]}));
        end
      end
      if (mem_cs && mem_we) begin
        chk("wb_addr_aligned", 256'(mem_addr[4:0]), 256'h0);
        chk("wb_data", mem_data_o, gold_line(mem_addr[31:5]));
      end
      if (mem_cs && !mem_we) chk("fetch_addr", 256'(mem_addr), 256'({addr[31:5], 5'b00000}));
      if (sram_we && stall) begin
        chk("refill_line", line_wr, gold_line(addr[31:5]));
        chk("refill_tag", 256'(tag_wr), 256'({2'b10, addr[31:10]}));
      end
    end
  end

  // ---------------- access task ----------------
  int          last_stalls;
  bit          last_first_stall;
  logic [31:0] last_rdata;
  logic [255:0] last_line_wr;
  logic [23:0] last_tag_wr;
  logic [31:0] rq_addr [$];
  bit          rq_we   [$];
  logic [31:0] rq_w1   [$];

  task automatic access(input logic [31:0] a, input bit w, input logic [31:0] d);
    logic [4:0]  idx;
    bit          hit, wbk, in_req, done;
    logic [31:0] wb_a, ra;
    bit          rw;
    int          exp_st;
    idx    = a[9:5];
    hit    = cm_valid[idx] && (cm_tag[idx] == a[31:10]);
    wbk    = !hit && cm_valid[idx] && cm_dirty[idx];
    wb_a   = {cm_tag[idx], idx, 5'b00000};
    exp_st = hit ? 0 : (wbk ? 2*ack_lat + 1 : ack_lat + 1);
    addr = a; we = w; data_i = d; cs = 1'b1;
    rq_addr.delete(); rq_we.delete(); rq_w1.delete();
    last_stalls = 0; in_req = 1'b0; done = 1'b0; ra = 32'h0; rw = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (c == 0) last_first_stall = stall;
      if (mem_cs) begin
        if (!in_req) begin
          rq_addr.push_back(mem_addr); rq_we.push_back(mem_we); rq_w1.push_back(mem_data_o[63:32]);
          ra = mem_addr; rw = mem_we; in_req = 1'b1;
        end else begin
          chk("mem_addr_stable", 256'(mem_addr), 256'(ra));
          chk("mem_we_stable", 256'(mem_we), 256'(rw));
        end
        if (mem_ack) in_req = 1'b0;
      end else begin
        in_req = 1'b0;
      end
      if (stall) last_stalls++;
      else begin
        done = 1'b1; last_rdata = data_o; last_line_wr = line_wr; last_tag_wr = tag_wr;
      end
    end
    chk("access_completes", 256'(done), 256'h1);
    chk("stall_cycles", 256'(last_stalls), 256'(exp_st));
    chk("request_count", 256'(rq_addr.size()), 256'(hit ? 0 : (wbk ? 2 : 1)));
    if (wbk && rq_addr.size() == 2) begin
      chk("wb_req_addr", 256'(rq_addr[0]), 256'(wb_a));
      chk("wb_req_we", 256'(rq_we[0]), 256'h1);
      chk("alloc_req_addr", 256'(rq_addr[1]), 256'({a[31:5], 5'b00000}));
      chk("alloc_req_we", 256'(rq_we[1]), 256'h0);
    end else if (!hit && !wbk && rq_addr.size() == 1) begin
      chk("alloc_req_addr", 256'(rq_addr[0]), 256'({a[31:5], 5'b00000}));
      chk("alloc_req_we", 256'(rq_we[0]), 256'h0);
    end
    @(posedge clk);
    if (done) begin
      cm_dirty[idx] = (hit ? cm_dirty[idx] : 1'b0) | w;
      cm_valid[idx] = 1'b1;
      cm_tag[idx]   = a[31:10];
      if (w) ovr[a[31:2]] = d;
`ifdef L1_CACHE_STATS_EN
      if (hit) exp_hits++; else exp_misses++;
`endif
    end
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      cm_valid[i] = 1'b0; cm_dirty[i] = 1'b0; cm_tag[i] = 22'h0;
    end
    ovr.delete();
`ifdef L1_CACHE_STATS_EN
    exp_hits = 0; exp_misses = 0;
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] l;
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 32'h0; data_i = 32'h0;
    for (int i = 0; i < 32; i++) begin
      tag_mem[i] = 24'h0; data_mem[i] = 256'h0;
    end
    l = mm_line(27'h2);
    l[95:64] = 32'hDEAD_BEEF;
    mm[27'h2] = l;
    model_reset();

    // reset: outputs quiet while rst is high and right after release
    @(negedge clk);
    chk("rst_stall", 256'(stall), 256'h0);
    chk("rst_mem_cs", 256'(mem_cs), 256'h0);
    chk("rst_sram_we", 256'(sram_we), 256'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 256'(stall), 256'h0);
    chk("post_rst_data_o", 256'(data_o), 256'h0);
    @(posedge clk); #1;

    // clean miss on 0x40, then load hit on 0x48
    ack_lat = 2;
    access(32'h0000_0040, 1'b0, 32'h0);
    chk("miss_first_stall", 256'(last_first_stall), 256'h1);
    chk("miss_penalty_lat2", 256'(last_stalls), 256'd3);
    if (rq_addr.size() >= 1) begin
      chk("lit_alloc_addr", 256'(rq_addr[0]), 256'h40);
      chk("lit_alloc_we", 256'(rq_we[0]), 256'h0);
    end
    access(32'h0000_0048, 1'b0, 32'h0);
    chk("lit_load_deadbeef", 256'(last_rdata), 256'hDEAD_BEEF);
    chk("lit_hit_no_stall", 256'(last_stalls), 256'd0);

    // store hit merges word 1
    access(32'h0000_0044, 1'b1, 32'h1234_5678);
    chk("lit_merge_word1", 256'(last_line_wr[63:32]), 256'h1234_5678);
    chk("lit_merge_word2", 256'(last_line_wr[95:64]), 256'hDEAD_BEEF);
    chk("lit_merge_word0", 256'(last_line_wr[31:0]), 256'h0040_FFBF);
    chk("lit_store_tag", 256'(last_tag_wr), 256'hC0_0000);

    // conflicting tag on index 2 with slow memory: write-back then allocate
    ack_lat = 5;
    access(32'h0000_0440, 1'b0, 32'h0);
    chk("lit_dirty_penalty", 256'(last_stalls), 256'd11);
    if (rq_addr.size() >= 2) begin
      chk("lit_wb_addr", 256'(rq_addr[0]), 256'h40);
      chk("lit_wb_we", 256'(rq_we[0]), 256'h1);
      chk("lit_wb_word1", 256'(rq_w1[0]), 256'h1234_5678);
      chk("lit_alloc2_addr", 256'(rq_addr[1]), 256'h440);
      chk("lit_alloc2_we", 256'(rq_we[1]), 256'h0);
    end
    chk("lit_load_0x440", 256'(last_rdata), 256'h0440_FBBF);

    // written-back data comes back from memory
    ack_lat = 3;
    access(32'h0000_0048, 1'b0, 32'h0);
    chk("lit_refetch_deadbeef", 256'(last_rdata), 256'hDEAD_BEEF);
    access(32'h0000_0044, 1'b0, 32'h0);
    chk("lit_refetch_store", 256'(last_rdata), 256'h1234_5678);

    // top line of the address space, word 7 store miss, word 0 load
    ack_lat = 1;
    access(32'hFFFF_FFFC, 1'b1, 32'hCAFE_F00D);
    access(32'hFFFF_FFE0, 1'b0, 32'h0);
    chk("lit_top_word0", 256'(last_rdata), 256'h001F_001F);

    // spurious ack while idle is ignored
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    @(posedge clk); #1;
    access(32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("lit_top_word7", 256'(last_rdata), 256'hCAFE_F00D);
    chk("lit_spur_still_hit", 256'(last_stalls), 256'd0);

    // evict the dirty top line through index 31
    ack_lat = 2;
    access(32'h0000_03E0, 1'b0, 32'h0);
    if (rq_addr.size() >= 1) chk("lit_evict_top", 256'(rq_addr[0]), 256'hFFFF_FFE0);

    // reset in the middle of an allocate
    ack_lat = 50;
    addr = 32'h0000_0C48; we = 1'b0; cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("lit_alloc_pending", 256'(mem_cs), 256'h1);
    chk("lit_alloc_pending_addr", 256'(mem_addr), 256'hC40);
    @(posedge clk); #1;
    rst = 1'b1; cs = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("lit_abort_mem_cs", 256'(mem_cs), 256'h0);
    chk("lit_abort_stall", 256'(stall), 256'h0);
    @(posedge clk); #1;
    ack_lat = 2;
    access(32'h0000_0048, 1'b0, 32'h0);
    chk("lit_post_rst_miss", 256'(last_stalls), 256'd3);
    chk("lit_post_rst_data", 256'(last_rdata), 256'hDEAD_BEEF);
    access(32'h0000_004C, 1'b0, 32'h0);
    access(32'h0000_0044, 1'b0, 32'h0);
    access(32'h0000_0040, 1'b0, 32'h0);

    @(posedge clk); #1;
`ifdef L1_CACHE_STATS_EN
    @(negedge clk);
    chk("hit_cnt", 256'(hit_cnt), 256'(exp_hits));
    chk("miss_cnt", 256'(miss_cnt), 256'(exp_misses));
    chk("lit_hit_cnt", 256'(hit_cnt), 256'd3);
    chk("lit_miss_cnt", 256'(miss_cnt), 256'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
